// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared widths, reset defaults and IF/ID record for the MIPS core
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int WORD_W     = 32;
    localparam int INSTR_W    = 32;
    localparam int IMM_W      = 16;

    localparam logic [WORD_W-1:0]  RESET_PC_DEFAULT  = 32'h0000_3000;
    localparam int                 IM_ADDR_W_DEFAULT = 10;

    localparam logic [INSTR_W-1:0] NOP_WORD    = 32'h0000_0000;
    localparam logic [WORD_W-1:0]  PC_STEP     = 32'd4;
    localparam logic [WORD_W-1:0]  LINK_OFFSET = 32'd8;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [WORD_W-1:0]  pc;
        logic               valid;
        logic               adel;
    } ifid_t;

    function automatic ifid_t make_bubble(input logic [WORD_W-1:0] pc);
        ifid_t e;
        e.instr = NOP_WORD;
        e.pc    = pc;
        e.valid = 1'b0;
        e.adel  = 1'b0;
        return e;
    endfunction

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/npc_sel.sv
// ============================================================================
// npc_sel : next-PC mux plus instruction-memory offset and fetch-error check
// Revision: 1.0
// ============================================================================
`default_nettype none

module npc_sel
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int                IM_ADDR_W = IM_ADDR_W_DEFAULT
) (
    input  logic [WORD_W-1:0]    pc_f,
    input  logic                 redirect_valid,
    input  logic [WORD_W-1:0]    redirect_pc,
    output logic [WORD_W-1:0]    npc,
    output logic [IM_ADDR_W-1:0] imem_addr,
    output logic                 fetch_err
);

    logic [WORD_W-1:0] w_off;
    logic              w_misaligned;
    logic              w_out_of_range;

    always_comb begin
        w_off          = pc_f - RESET_PC;
        w_misaligned   = (pc_f[1:0] != 2'b00);
        // Any offset bit at or above byte 4*2^IM_ADDR_W lies past the ROM.
        w_out_of_range = ((w_off >> (IM_ADDR_W + 2)) != '0);
        fetch_err      = w_misaligned | w_out_of_range;
        imem_addr      = w_off[IM_ADDR_W+1:2];
        npc            = redirect_valid ? redirect_pc : (pc_f + PC_STEP);
    end

endmodule : npc_sel

`default_nettype wire

// File: rtl/if_id_fetch_stage.sv
// ============================================================================
// if_id_fetch_stage : fetch PC register and IF/ID pipeline register
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_id_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int                IM_ADDR_W = IM_ADDR_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect_valid,
    input  logic [WORD_W-1:0]    redirect_pc,
    output logic [IM_ADDR_W-1:0] imem_addr,
    input  logic [INSTR_W-1:0]   imem_rdata,
    output logic [WORD_W-1:0]    pc_f,
    output logic [INSTR_W-1:0]   instr_d,
    output logic [IMM_W-1:0]     imm16_d,
    output logic [WORD_W-1:0]    pc_d,
    output logic [WORD_W-1:0]    pc8_d,
    output logic                 valid_d,
    output logic                 adel_d
);

    logic [WORD_W-1:0] r_pc_f;
    ifid_t             r_ifid;
    ifid_t             w_fetched;
    logic [WORD_W-1:0] w_npc;
    logic              w_fetch_err;

    npc_sel #(
        .RESET_PC  (RESET_PC),
        .IM_ADDR_W (IM_ADDR_W)
    ) u_npc_sel (
        .pc_f           (r_pc_f),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .npc            (w_npc),
        .imem_addr      (imem_addr),
        .fetch_err      (w_fetch_err)
    );

    always_comb begin
        w_fetched.instr = w_fetch_err ? NOP_WORD : imem_rdata;
        w_fetched.pc    = r_pc_f;
        w_fetched.valid = 1'b1;
        w_fetched.adel  = w_fetch_err;
    end

    // Flush and stall act independently on the two registers: flush always
    // bubbles IF/ID, while stall alone decides whether the PC advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_f <= RESET_PC;
            r_ifid <= make_bubble(RESET_PC);
        end else begin
            if (!stall) begin
                r_pc_f <= w_npc;
            end
            if (flush) begin
                r_ifid <= make_bubble(r_pc_f);
            end else if (!stall) begin
                r_ifid <= w_fetched;
            end
        end
    end

    assign pc_f    = r_pc_f;
    assign instr_d = r_ifid.instr;
    assign imm16_d = r_ifid.instr[IMM_W-1:0];
    assign pc_d    = r_ifid.pc;
    assign pc8_d   = r_ifid.pc + LINK_OFFSET;
    assign valid_d = r_ifid.valid;
    assign adel_d  = r_ifid.adel;

endmodule : if_id_fetch_stage

`default_nettype wire

// File: tb/tb_if_id_fetch_stage.sv
// ============================================================================
// tb_if_id_fetch_stage : directed vector table plus randomized model check
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_id_fetch_stage;

    localparam logic [31:0] RPC  = 32'h0000_3000;
    localparam int          IMW  = 10;
    localparam int          NROM = 1 << IMW;
    localparam logic [31:0] ROM_BYTES = 32'd4 << IMW;
    localparam int          NVEC = 20;
    localparam int          NRND = 600;

    logic           clk;
    logic           reset;
    logic           stall;
    logic           flush;
    logic           redirect_valid;
    logic [31:0]    redirect_pc;
    logic [IMW-1:0] imem_addr;
    logic [31:0]    imem_rdata;
    logic [31:0]    pc_f;
    logic [31:0]    instr_d;
    logic [15:0]    imm16_d;
    logic [31:0]    pc_d;
    logic [31:0]    pc8_d;
    logic           valid_d;
    logic           adel_d;

    logic [31:0] rom [0:NROM-1];

    int total;
    int bad;

    typedef struct {
        logic        st;
        logic        fl;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pcd;
        logic        e_v;
        logic        e_a;
    } vec_t;

    vec_t tbl [NVEC];

    // reference model state
    logic [31:0] m_pc, m_instr, m_pcd;
    logic        m_v, m_a;

    if_id_fetch_stage #(
        .RESET_PC  (RPC),
        .IM_ADDR_W (IMW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc_f           (pc_f),
        .instr_d        (instr_d),
        .imm16_d        (imm16_d),
        .pc_d           (pc_d),
        .pc8_d          (pc8_d),
        .valid_d        (valid_d),
        .adel_d         (adel_d)
    );

    assign imem_rdata = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pcd, input logic e_v, input logic e_a);
        logic [31:0] off;
        off = e_pc - RPC;
        chk("pc_f",      pc_f,            e_pc);
        chk("instr_d",   instr_d,         e_instr);
        chk("pc_d",      pc_d,            e_pcd);
        chk("pc8_d",     pc8_d,           e_pcd + 32'd8);
        chk("imm16_d",   {16'h0, imm16_d}, {16'h0, e_instr[15:0]});
        chk("valid_d",   {31'h0, valid_d}, {31'h0, e_v});
        chk("adel_d",    {31'h0, adel_d},  {31'h0, e_a});
        chk("imem_addr", {{(32-IMW){1'b0}}, imem_addr}, (off / 32'd4) % NROM);
    endtask

    // Spec-level fetch: what a fetch of address pc delivers to ID.
    function automatic logic fetch_bad(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - RPC;
        return (pc % 4 != 0) || (off >= ROM_BYTES);
    endfunction

    function automatic logic [31:0] fetch_word(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - RPC;
        if (fetch_bad(pc)) return 32'h0;
        return rom[off / 4];
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_instr = 32'h0; m_pcd = RPC; m_v = 1'b0; m_a = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
        logic [31:0] nxt;
        nxt = rv ? rpc : m_pc + 32'd4;
        if (fl) begin
            m_instr = 32'h0; m_v = 1'b0; m_a = 1'b0; m_pcd = m_pc;
            if (!st) m_pc = nxt;
        end else if (!st) begin
            m_instr = fetch_word(m_pc);
            m_a     = fetch_bad(m_pc);
            m_v     = 1'b1;
            m_pcd   = m_pc;
            m_pc    = nxt;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < NROM; i++) rom[i] = 32'h2400_0000 + i;
        rom[0] = 32'h3c01_1234;
        rom[1] = 32'h3421_5678;

        //            st fl rv rpc            pc_f          instr_d       pc_d          v  a
        tbl[0]  = '{0, 0, 0, 32'h0,         32'h3004, 32'h3c01_1234, 32'h3000, 1, 0};
        tbl[1]  = '{0, 0, 0, 32'h0,         32'h3008, 32'h3421_5678, 32'h3004, 1, 0};
        tbl[2]  = '{0, 0, 1, 32'h3020,      32'h3020, 32'h2400_0002, 32'h3008, 1, 0};
        tbl[3]  = '{0, 0, 0, 32'h0,         32'h3024, 32'h2400_0008, 32'h3020, 1, 0};
        tbl[4]  = '{0, 0, 0, 32'h0,         32'h3028, 32'h2400_0009, 32'h3024, 1, 0};
        tbl[5]  = '{0, 0, 1, 32'h3008,      32'h3008, 32'h2400_000a, 32'h3028, 1, 0};
        tbl[6]  = '{0, 0, 0, 32'h0,         32'h300c, 32'h2400_0002, 32'h3008, 1, 0};
        tbl[7]  = '{1, 0, 1, 32'h3040,      32'h300c, 32'h2400_0002, 32'h3008, 1, 0};
        tbl[8]  = '{1, 0, 1, 32'h3040,      32'h300c, 32'h2400_0002, 32'h3008, 1, 0};
        tbl[9]  = '{1, 0, 1, 32'h3040,      32'h300c, 32'h2400_0002, 32'h3008, 1, 0};
        tbl[10] = '{0, 0, 1, 32'h3040,      32'h3040, 32'h2400_0003, 32'h300c, 1, 0};
        tbl[11] = '{0, 0, 1, 32'h3010,      32'h3010, 32'h2400_0010, 32'h3040, 1, 0};
        tbl[12] = '{1, 1, 0, 32'h0,         32'h3010, 32'h0,         32'h3010, 0, 0};
        tbl[13] = '{0, 0, 0, 32'h0,         32'h3014, 32'h2400_0004, 32'h3010, 1, 0};
        tbl[14] = '{0, 0, 1, 32'h3002,      32'h3002, 32'h2400_0005, 32'h3014, 1, 0};
        tbl[15] = '{0, 0, 0, 32'h0,         32'h3006, 32'h0,         32'h3002, 1, 1};
        tbl[16] = '{0, 0, 1, 32'h4000,      32'h4000, 32'h0,         32'h3006, 1, 1};
        tbl[17] = '{0, 0, 0, 32'h0,         32'h4004, 32'h0,         32'h4000, 1, 1};
        tbl[18] = '{0, 1, 1, 32'h3020,      32'h3020, 32'h0,         32'h4004, 0, 0};
        tbl[19] = '{0, 0, 0, 32'h0,         32'h3024, 32'h2400_0008, 32'h3020, 1, 0};

        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all(RPC, 32'h0, RPC, 1'b0, 1'b0);

        reset = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            stall = tbl[i].st; flush = tbl[i].fl;
            redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
            @(posedge clk); #1;
            chk_all(tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_pcd, tbl[i].e_v, tbl[i].e_a);
            @(negedge clk);
        end

        // Asynchronous reset in mid-cycle at pc_f=3024: outputs clear before any edge.
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        #2;
        chk("pre_reset_pc_f", pc_f, 32'h3024);
        reset = 1'b0;
        #1;
        chk_all(RPC, 32'h0, RPC, 1'b0, 1'b0);
        @(negedge clk);

        // Randomized phase against the reference model with a fresh ROM image.
        for (int i = 0; i < NROM; i++) rom[i] = $urandom;
        model_reset();
        reset = 1'b1;
        for (int n = 0; n < NRND; n++) begin
            logic st, fl, rv;
            logic [31:0] rpc;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            rv = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 5))
                0:       rpc = RPC + ($urandom_range(0, NROM - 1) * 4) + $urandom_range(1, 3);
                1:       rpc = RPC + ROM_BYTES + ($urandom_range(0, 15) * 4);
                2:       rpc = 32'hFFFF_FFF8 + ($urandom_range(0, 1) * 4);
                3:       rpc = RPC + ROM_BYTES - 32'd4;
                default: rpc = RPC + ($urandom_range(0, NROM - 1) * 4);
            endcase
            stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
            model_step(st, fl, rv, rpc);
            @(posedge clk); #1;
            chk_all(m_pc, m_instr, m_pcd, m_v, m_a);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_if_id_fetch_stage

`default_nettype wire
